// File: rtl/sudoku_pkg.sv
// Shared constants for the game front end: button bit map, debounce FSM encoding, clock rate.
package sudoku_pkg;

    localparam int CLK_HZ = 50_000_000;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_START = 4;
    localparam int BTN_A     = 5;
    localparam int BTN_B     = 6;

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_PEND   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_PEND = 2'd3
    } db_state_t;

endpackage

// File: rtl/button_debounce.sv
// One button: 2-flop synchroniser, debounce FSM with saturating counter, registered press pulse.
// Optional auto-repeat while held is compiled in only with BUTTON_AUTO_REPEAT_EN.
module button_debounce
    import sudoku_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
`ifdef BUTTON_AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 7500000,
    parameter bit REPEAT_EN       = 1'b0
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic level,
    output logic pulse
);

    // The sample that moves the FSM out of a settled state is the first stable cycle,
    // so the pending state only needs DEBOUNCE_CYCLES-1 further matching samples.
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES - 2 : 0);
    localparam bit FAST = (DEBOUNCE_CYCLES <= 1);

    logic [1:0]       sync_ff;
    logic             sync;
    db_state_t        state;
    logic [CNT_W-1:0] cnt;

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_DELAY + 1);
    localparam logic [RPT_W-1:0] RPT_FIRE   = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);
    logic [RPT_W-1:0] rcnt;
`endif

    assign sync = sync_ff[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_ff <= '0;
            state   <= ST_RELEASED;
            cnt     <= '0;
            level   <= 1'b0;
            pulse   <= 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
            rcnt    <= '0;
`endif
        end else begin
            sync_ff <= {sync_ff[0], btn_in};
            pulse   <= 1'b0;
            unique case (state)
                ST_RELEASED:
                    if (sync) begin
                        cnt <= '0;
                        if (FAST) begin
                            state <= ST_PRESSED;
                            level <= 1'b1;
                            pulse <= 1'b1;
                        end else begin
                            state <= ST_PRESS_PEND;
                        end
                    end
                ST_PRESS_PEND:
                    if (!sync) begin
                        state <= ST_RELEASED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= ST_PRESSED;
                        level <= 1'b1;
                        pulse <= 1'b1;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                ST_PRESSED:
                    if (!sync) begin
                        cnt <= '0;
                        if (FAST) begin
                            state <= ST_RELEASED;
                            level <= 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
                            rcnt  <= '0;
`endif
                        end else begin
                            state <= ST_RELEASE_PEND;
                        end
                    end
`ifdef BUTTON_AUTO_REPEAT_EN
                    // First repeat REPEAT_DELAY after the press pulse, then reload so the
                    // next fire lands REPEAT_PERIOD later.
                    else if (REPEAT_EN) begin
                        if (rcnt == RPT_FIRE) begin
                            pulse <= 1'b1;
                            rcnt  <= RPT_RELOAD;
                        end else begin
                            rcnt <= rcnt + 1'b1;
                        end
                    end
`endif
                ST_RELEASE_PEND:
                    if (sync) begin
                        state <= ST_PRESSED;
                    end else if (cnt == CNT_LAST) begin
                        state <= ST_RELEASED;
                        level <= 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
                        rcnt  <= '0;
`endif
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                default: state <= ST_RELEASED;
            endcase
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Board push-buttons -> debounced levels and single-cycle press pulses for the game FSM.
// Define BUTTON_AUTO_REPEAT_EN to auto-repeat the four direction buttons while held.
module button_conditioner
    import sudoku_pkg::*;
#(
    parameter int N_BTN           = 7,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 7500000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse
);

    logic [N_BTN-1:0] btn_norm;

    assign btn_norm = ACTIVE_LOW ? ~btn_raw : btn_raw;

    if (DEBOUNCE_CYCLES < 1 || $clog2(DEBOUNCE_CYCLES) > CNT_W ||
        REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_cfg
        $error("button_conditioner: inconsistent debounce/repeat parameters");
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
`ifdef BUTTON_AUTO_REPEAT_EN
            ,
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .REPEAT_EN       (i <= BTN_RIGHT)
`endif
        ) u_db (
            .clk    (clk),
            .reset  (reset),
            .btn_in (btn_norm[i]),
            .level  (btn_level[i]),
            .pulse  (btn_pulse[i])
        );
    end

endmodule
